// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation codes,
// burst FSM state type and the shift-mode classifier.
package usr_pkg;

    // Operation select codes presented on the mode input.
    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROTL = 3'b100;
    localparam logic [2:0] MODE_ROTR = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;

    // Burst controller states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // True for modes that move bits and therefore make sense in a burst.
    function automatic logic is_shift_mode(input logic [2:0] m);
        case (m)
            MODE_SHL, MODE_SHR, MODE_ROTL, MODE_ROTR, MODE_ASR: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/usr_shift_step.sv
// One-step next-value function of the universal shift register.
// Purely combinational; the caller decides when the result is committed.
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       i_mode,
    input  logic [WIDTH-1:0] i_d,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic             i_sft_left,
    input  logic             i_sft_right,
    output logic [WIDTH-1:0] o_next
);

    // Select the next register value for the requested operation.
    always_comb begin
        o_next = i_d;
        case (i_mode)
            MODE_SHL:  o_next = {i_d[WIDTH-2:0], i_sft_left};
            MODE_SHR:  o_next = {i_sft_right, i_d[WIDTH-1:1]};
            MODE_LOAD: o_next = i_data_in;
            MODE_ROTL: o_next = {i_d[WIDTH-2:0], i_d[WIDTH-1]};
            MODE_ROTR: o_next = {i_d[0], i_d[WIDTH-1:1]};
            MODE_ASR:  o_next = {i_d[WIDTH-1], i_d[WIDTH-1:1]};
            default:   o_next = i_d;
        endcase
    end

endmodule

// File: rtl/universal_shift_reg_p.sv
// Parametrised universal shift register with single-cycle operations and a
// multi-cycle burst shift (start/amt -> busy/done).
module universal_shift_reg_p
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic             sft_left,
    input  logic             sft_right,
    input  logic             start,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] data_out,
    output logic             q_left,
    output logic             q_right,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic [AMT_W-1:0] r_cnt;
    logic [2:0]       r_mode;
    logic             r_done;

    logic [2:0]       w_step_mode;
    logic [WIDTH-1:0] w_next;
    logic             w_burst_go;

    // During a burst the latched mode drives the step; otherwise the live input.
    assign w_step_mode = (r_state == ST_BUSY) ? r_mode : mode;
    assign w_burst_go  = start && is_shift_mode(mode) && (amt != '0);

    usr_shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_mode      (w_step_mode),
        .i_d         (r_data),
        .i_data_in   (data_in),
        .i_sft_left  (sft_left),
        .i_sft_right (sft_right),
        .o_next      (w_next)
    );

    // Burst FSM, step counter and data register; en=0 freezes everything but
    // done, which is only ever high for one enabled completion edge.
    // The counter holds the steps still to perform after the current one, so
    // a burst of amt steps stays BUSY for amt enabled cycles and completes on
    // the following enabled edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
            r_mode  <= MODE_HOLD;
            r_done  <= 1'b0;
        end else if (!en) begin
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_burst_go) begin
                            r_data  <= w_next;
                            r_mode  <= mode;
                            r_cnt   <= amt - AMT_W'(1);
                            r_state <= ST_BUSY;
                        end else begin
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_data <= w_next;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != '0) begin
                        r_data <= w_next;
                        r_cnt  <= r_cnt - AMT_W'(1);
                    end else begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign data_out = r_data;
    assign q_left   = r_data[WIDTH-1];
    assign q_right  = r_data[0];
    assign busy     = (r_state == ST_BUSY);
    assign done     = r_done;

endmodule

// File: tb/tb_universal_shift_reg_p.sv
// Self-checking bench for universal_shift_reg_p (WIDTH=8): directed scenarios
// followed by randomized traffic, all compared against an arithmetic model.
module tb_universal_shift_reg_p;

    localparam int W  = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [2:0]    mode;
    logic [W-1:0]  data_in;
    logic          sft_left;
    logic          sft_right;
    logic          start;
    logic [AW-1:0] amt;
    logic [W-1:0]  data_out;
    logic          q_left;
    logic          q_right;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (plain integers).
    int m_data  = 0;
    int m_left  = 0;   // burst steps still owed after the current enabled cycle
    int m_mode  = 0;
    bit m_busy  = 1'b0;
    bit m_done  = 1'b0;

    universal_shift_reg_p #(
        .WIDTH(W),
        .AMT_W(AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .data_in   (data_in),
        .sft_left  (sft_left),
        .sft_right (sft_right),
        .start     (start),
        .amt       (amt),
        .data_out  (data_out),
        .q_left    (q_left),
        .q_right   (q_right),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One operation expressed with integer arithmetic on an 8-bit value.
    function automatic int ref_op(input int m, input int v, input int sl, input int sr, input int din);
        case (m)
            1:       return (v * 2 + sl) % 256;
            2:       return v / 2 + sr * 128;
            3:       return din;
            4:       return (v * 2) % 256 + v / 128;
            5:       return v / 2 + (v % 2) * 128;
            6:       return v / 2 + ((v >= 128) ? 128 : 0);
            default: return v;
        endcase
    endfunction

    function automatic bit is_shift(input int m);
        return (m == 1) || (m == 2) || (m == 4) || (m == 5) || (m == 6);
    endfunction

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_edge();
        int sl, sr, din;
        sl  = int'(sft_left);
        sr  = int'(sft_right);
        din = int'(data_in);
        if (reset) begin
            m_data = 0; m_left = 0; m_mode = 0; m_busy = 1'b0; m_done = 1'b0;
        end else if (!en) begin
            m_done = 1'b0;
        end else if (m_busy) begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_data = ref_op(m_mode, m_data, sl, sr, din);
                m_left--;
            end else begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else if (start) begin
            if (is_shift(int'(mode)) && amt != 0) begin
                m_mode = int'(mode);
                m_data = ref_op(m_mode, m_data, sl, sr, din);
                m_left = int'(amt) - 1;
                m_busy = 1'b1;
                m_done = 1'b0;
            end else begin
                m_done = 1'b1;
            end
        end else begin
            m_data = ref_op(int'(mode), m_data, sl, sr, din);
            m_done = 1'b0;
        end
    endtask

    // Clock one edge, update the model, then compare all outputs.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("data_out", 32'(data_out), 32'(m_data));
        chk("q_left",   32'(q_left),   32'(m_data / 128));
        chk("q_right",  32'(q_right),  32'(m_data % 2));
        chk("busy",     32'(busy),     32'(m_busy));
        chk("done",     32'(done),     32'(m_done));
    endtask

    task automatic drive(input bit e, input int m, input int din, input bit st, input int a,
                         input bit sl, input bit sr);
        en        = e;
        mode      = 3'(m);
        data_in   = 8'(din);
        start     = st;
        amt       = 4'(a);
        sft_left  = sl;
        sft_right = sr;
    endtask

    initial begin
        int busy_cycles;
        int done_pulses;
        reset = 1'b1;
        drive(1'b1, 0, 0, 1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);

        // Reset state.
        repeat (2) tick();
        chk("rst_data", 32'(data_out), 32'h00);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        reset = 1'b0;

        // Load then shift left with serial 1.
        drive(1'b1, 3, 'hA5, 1'b0, 0, 1'b0, 1'b0); tick();
        chk("t2_load", 32'(data_out), 32'hA5);
        drive(1'b1, 1, 0, 1'b0, 0, 1'b1, 1'b0); tick();
        chk("t2_shl", 32'(data_out), 32'h4B);
        chk("t2_qr", 32'(q_right), 32'h1);

        // Arithmetic shift right then logical shift right.
        drive(1'b1, 3, 'h96, 1'b0, 0, 1'b0, 1'b0); tick();
        drive(1'b1, 6, 0, 1'b0, 0, 1'b0, 1'b0); tick();
        chk("t3_asr", 32'(data_out), 32'hCB);
        drive(1'b1, 2, 0, 1'b0, 0, 1'b0, 1'b0); tick();
        chk("t3_shr", 32'(data_out), 32'h65);

        // Rotate-left burst of 3.
        drive(1'b1, 3, 'h81, 1'b0, 0, 1'b0, 1'b0); tick();
        drive(1'b1, 4, 0, 1'b1, 3, 1'b0, 1'b0); tick();
        chk("t4_s1", 32'(data_out), 32'h03);
        drive(1'b1, 0, 0, 1'b0, 0, 1'b0, 1'b0); tick();
        chk("t4_s2", 32'(data_out), 32'h06);
        tick();
        chk("t4_s3", 32'(data_out), 32'h0C);
        chk("t4_busy", 32'(busy), 32'h1);
        tick();
        chk("t4_done", 32'(done), 32'h1);
        chk("t4_idle", 32'(busy), 32'h0);
        tick();
        chk("t4_done_pulse", 32'(done), 32'h0);

        // Rotate-right burst of 4 with a two-cycle stall.
        drive(1'b1, 3, 'hF0, 1'b0, 0, 1'b0, 1'b0); tick();
        busy_cycles = 0;
        done_pulses = 0;
        drive(1'b1, 5, 0, 1'b1, 4, 1'b0, 1'b0); tick();
        busy_cycles += int'(busy);
        drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
        repeat (2) begin
            tick();
            chk("t5_frozen", 32'(data_out), 32'h78);
            busy_cycles += int'(busy);
        end
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            busy_cycles += int'(busy);
            done_pulses += int'(done);
        end
        chk("t5_final", 32'(data_out), 32'h0F);
        chk("t5_busy_cycles", 32'(busy_cycles), 32'd6);
        chk("t5_done_pulses", 32'(done_pulses), 32'd1);

        // Reset mid-burst, then a zero-length start.
        drive(1'b1, 3, 'hFF, 1'b0, 0, 1'b0, 1'b0); tick();
        drive(1'b1, 2, 0, 1'b1, 5, 1'b0, 1'b0); tick();
        drive(1'b1, 0, 0, 1'b0, 0, 1'b0, 1'b0); tick();
        chk("t6_two_steps", 32'(data_out), 32'h3F);
        reset = 1'b1; tick();
        chk("t6_rst_data", 32'(data_out), 32'h00);
        chk("t6_rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        drive(1'b1, 3, 'h5A, 1'b0, 0, 1'b0, 1'b0); tick();
        chk("t6_no_done", 32'(done), 32'h0);
        drive(1'b1, 1, 0, 1'b1, 0, 1'b1, 1'b0); tick();
        chk("t6_amt0_data", 32'(data_out), 32'h5A);
        chk("t6_amt0_done", 32'(done), 32'h1);
        chk("t6_amt0_busy", 32'(busy), 32'h0);
        drive(1'b1, 0, 0, 1'b0, 0, 1'b0, 1'b0); tick();
        chk("t6_done_clear", 32'(done), 32'h0);

        // Randomized traffic including oversized burst counts and stalls.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 9) < 8, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                  $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
